// File: rtl/itm_trace_compression_param_if.sv
// rtl/itm_trace_compression_param_if.sv - trace input, message output and drop status bundle
interface itm_trace_compression_param_if #(
  parameter int TS_WIDTH   = 32,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 8,
  parameter int DROP_WIDTH = 16
);
  logic [TS_WIDTH+PC_WIDTH-1:0]           trace_in;
  logic                                   trace_in_valid;
  logic                                   flush;
  logic [TS_WIDTH+PC_WIDTH+CNT_WIDTH-1:0] out_data;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [DROP_WIDTH-1:0]                  drop_cnt;
  logic                                   drop_pulse;

  modport master (
    output trace_in, trace_in_valid, flush, out_ready,
    input  out_data, out_valid, drop_cnt, drop_pulse
  );

  modport slave (
    input  trace_in, trace_in_valid, flush, out_ready,
    output out_data, out_valid, drop_cnt, drop_pulse
  );
endinterface

// File: rtl/itm_trace_compression_param.sv
// rtl/itm_trace_compression_param.sv - per-instruction trace to basic-block messages
// Blocks are {start ts, start pc, count}; messages queue in a small FIFO with drop accounting.
module itm_trace_compression_param #(
  parameter int                  TS_WIDTH   = 32,
  parameter int                  PC_WIDTH   = 32,
  parameter int                  CNT_WIDTH  = 8,
  parameter int                  PC_STEP    = 4,
  parameter logic [PC_WIDTH-1:0] BOOT_ADR   = 'h100,
  parameter int                  FIFO_DEPTH = 4,
  parameter int                  DROP_WIDTH = 16
) (
  input logic                          clk,
  input logic                          rst,
  itm_trace_compression_param_if.slave bus
);
  localparam int MSG_W = TS_WIDTH + PC_WIDTH + CNT_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {WAIT_BOOT, RUN} state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   prev_pc_q, prev_pc_d;
  logic [PC_WIDTH-1:0]   sa_q, sa_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [MSG_W-1:0]      mem_q [FIFO_DEPTH];
  logic [MSG_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                  drop_pulse_q, drop_pulse_d;

  logic [TS_WIDTH-1:0]   in_ts;
  logic [PC_WIDTH-1:0]   in_pc;
  logic                  accept, seq, flush_emit, emit, push, pop;
  logic [MSG_W-1:0]      emit_data;

  assign in_ts = bus.trace_in[TS_WIDTH+PC_WIDTH-1:PC_WIDTH];
  assign in_pc = bus.trace_in[PC_WIDTH-1:0];

  always_comb begin
    accept     = bus.trace_in_valid && (in_pc != '0) && (state_q == RUN || in_pc == BOOT_ADR);
    seq        = (in_pc == prev_pc_q + PC_WIDTH'(PC_STEP)) || (in_pc == prev_pc_q);
    flush_emit = bus.flush && (state_q == RUN) && (cnt_q != '0);
    emit_data  = {ts_q, sa_q, cnt_q};
    emit       = 1'b0;
    state_d    = state_q;
    prev_pc_d  = prev_pc_q;
    sa_d       = sa_q;
    ts_d       = ts_q;
    cnt_d      = cnt_q;
    if (accept) begin
      prev_pc_d = in_pc;
      state_d   = RUN;
      if (state_q == RUN && seq && !flush_emit && cnt_q != '0 && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end else begin
        // A flush in the same cycle is folded into this emit: it closes the same prior block.
        emit  = (state_q == RUN) && (cnt_q != '0);
        sa_d  = in_pc;
        ts_d  = in_ts;
        cnt_d = CNT_WIDTH'(1);
      end
    end else if (flush_emit) begin
      emit  = 1'b1;
      cnt_d = '0;
    end
  end

  always_comb begin
    pop          = (count_q != '0) && bus.out_ready;
    push         = emit && ((count_q != FULL) || pop);
    mem_d        = mem_q;
    if (push) mem_d[wr_ptr_q] = emit_data;
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    count_d      = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    drop_pulse_d = emit && !push;
    drop_cnt_d   = drop_cnt_q;
    if (drop_pulse_d && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_BOOT;
      prev_pc_q    <= '0;
      sa_q         <= '0;
      ts_q         <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_pc_q    <= prev_pc_d;
      sa_q         <= sa_d;
      ts_q         <= ts_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.drop_pulse = drop_pulse_q;
endmodule

// File: tb/tb_itm_trace_compression_param.sv
// tb/tb_itm_trace_compression_param.sv - directed bench with queue-based reference model
module tb_itm_trace_compression_param;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   armed   = 0;
  int   pulses  = 0;
  logic [71:0] got[$];

  itm_trace_compression_param_if tif ();

  itm_trace_compression_param dut (
    .clk(clk),
    .rst(rst),
    .bus(tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] mk(logic [31:0] ts, logic [31:0] pc, logic [7:0] c);
    return {ts, pc, c};
  endfunction

  task automatic check(string name, logic [71:0] act, logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: block tracker plus a bounded message queue
  bit          m_run   = 0;
  logic [31:0] m_prev  = '0;
  int          m_cnt   = 0;
  logic [31:0] m_sa    = '0;
  logic [31:0] m_ts    = '0;
  logic [71:0] m_fifo[$];
  int          m_drop  = 0;
  bit          m_pulse = 0;
  bit          mv_have, mv_acc;
  logic [71:0] mv_msg;
  logic [31:0] mv_pc, mv_ts;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_run = 0; m_prev = '0; m_cnt = 0; m_sa = '0; m_ts = '0;
      m_fifo.delete(); m_drop = 0; m_pulse = 0;
    end else begin
      mv_have = 0;
      mv_msg  = '0;
      mv_pc   = tif.trace_in[31:0];
      mv_ts   = tif.trace_in[63:32];
      mv_acc  = tif.trace_in_valid && mv_pc != 0 && (m_run || mv_pc == 32'h100);
      if (m_run && tif.flush && m_cnt != 0) begin
        mv_have = 1; mv_msg = mk(m_ts, m_sa, 8'(m_cnt)); m_cnt = 0;
      end
      if (mv_acc) begin
        if (m_run && m_cnt != 0 && m_cnt < 255 && (mv_pc == m_prev || mv_pc == 32'(m_prev + 4))) begin
          m_cnt++;
        end else begin
          if (m_run && m_cnt != 0) begin mv_have = 1; mv_msg = mk(m_ts, m_sa, 8'(m_cnt)); end
          m_sa = mv_pc; m_ts = mv_ts; m_cnt = 1; m_run = 1;
        end
        m_prev = mv_pc;
      end
      if (m_fifo.size() != 0 && tif.out_ready) void'(m_fifo.pop_front());
      m_pulse = 0;
      if (mv_have) begin
        if (m_fifo.size() < 4) m_fifo.push_back(mv_msg);
        else begin
          m_pulse = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("out_valid", 72'(tif.out_valid), 72'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) check("out_data", tif.out_data, m_fifo[0]);
      check("drop_cnt", 72'(tif.drop_cnt), 72'(m_drop));
      check("drop_pulse", 72'(tif.drop_pulse), 72'(m_pulse));
      if (tif.drop_pulse) pulses++;
      if (tif.out_valid && tif.out_ready) got.push_back(tif.out_data);
    end
  end

  task automatic cyc(bit v, logic [31:0] ts, logic [31:0] pc, bit fl);
    tif.trace_in_valid = v;
    tif.trace_in       = {ts, pc};
    tif.flush          = fl;
    @(posedge clk); #1;
    tif.trace_in_valid = 1'b0;
    tif.flush          = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_got(string name, int idx, logic [71:0] exp);
    if (idx < got.size()) check(name, got[idx], exp);
    else check(name, 72'hDEAD, exp);
  endtask

  initial begin
    rst = 1'b1;
    tif.trace_in_valid = 1'b0;
    tif.trace_in       = '0;
    tif.flush          = 1'b0;
    tif.out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1;
    check("rst_out_valid", 72'(tif.out_valid), 72'd0);
    check("rst_out_data", tif.out_data, 72'd0);
    check("rst_drop_cnt", 72'(tif.drop_cnt), 72'd0);
    check("rst_drop_pulse", 72'(tif.drop_pulse), 72'd0);

    // Boot sync
    cyc(1, 1, 32'h50, 0);
    cyc(1, 2, 32'h0, 0);
    cyc(1, 10, 32'h100, 0);
    cyc(1, 11, 32'h104, 0);
    cyc(1, 12, 32'h108, 0);
    cyc(1, 13, 32'h200, 0);
    idle(3);
    check("boot_count", 72'(got.size()), 72'd1);
    check_got("boot_msg", 0, mk(10, 32'h100, 3));

    // Repeat/stall PCs with idle gaps
    cyc(0, 0, 0, 1);
    idle(3);
    check_got("flush_open", 1, mk(13, 32'h200, 1));
    got.delete();
    cyc(1, 20, 32'h100, 0);
    idle(3);
    cyc(1, 21, 32'h100, 0);
    idle(2);
    cyc(1, 22, 32'h104, 0);
    cyc(1, 23, 32'h300, 0);
    idle(3);
    check("repeat_count", 72'(got.size()), 72'd1);
    check_got("repeat_msg", 0, mk(20, 32'h100, 3));

    // Overflow split
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    got.delete();
    for (int i = 0; i < 256; i++) cyc(1, 100 + i, 32'h100 + 4 * i, 0);
    cyc(1, 400, 32'h1000, 0);
    idle(3);
    check("ovf_count", 72'(got.size()), 72'd2);
    check_got("ovf_msg", 0, mk(100, 32'h100, 8'hFF));
    check_got("ovf_next", 1, mk(355, 32'h4FC, 1));

    // Flush
    cyc(0, 0, 0, 1);
    idle(2);
    got.delete();
    cyc(1, 500, 32'h100, 0);
    cyc(1, 501, 32'h104, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 502, 32'h108, 0);
    cyc(1, 503, 32'h10C, 1);
    cyc(0, 0, 0, 1);
    idle(3);
    check("flush_count", 72'(got.size()), 72'd3);
    check_got("flush_msg", 0, mk(500, 32'h100, 2));
    check_got("flush_newstream", 1, mk(502, 32'h108, 1));
    check_got("flush_with_input", 2, mk(503, 32'h10C, 1));

    // Backpressure with drops
    got.delete();
    pulses = 0;
    tif.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) cyc(1, 600 + i, 32'h2000 + 32'h1000 * i, 0);
    idle(1);
    check("bp_drop_cnt", 72'(tif.drop_cnt), 72'd2);
    check("bp_pulses", 72'(pulses), 72'd2);
    tif.out_ready = 1'b1;
    idle(4);
    check("bp_drained", 72'(got.size()), 72'd4);
    check("bp_empty", 72'(tif.out_valid), 72'd0);
    for (int i = 0; i < 4; i++) check_got("bp_order", i, mk(600 + i, 32'h2000 + 32'h1000 * i, 1));

    // Push and pop together while full
    got.delete();
    tif.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 700 + i, 32'h9000 + 32'h1000 * i, 0);
    tif.out_ready = 1'b1;
    cyc(1, 704, 32'hD000, 0);
    idle(1);
    check("full_pushpop_drop", 72'(tif.drop_cnt), 72'd2);
    idle(5);
    check("full_drain", 72'(got.size()), 72'd5);
    check_got("full_first", 0, mk(606, 32'h8000, 1));
    check_got("full_last", 4, mk(703, 32'hC000, 1));

    // Asynchronous reset with two messages queued
    got.delete();
    tif.out_ready = 1'b0;
    cyc(1, 800, 32'hE000, 0);
    cyc(1, 801, 32'hF000, 0);
    cyc(1, 802, 32'hF004, 0);
    check("pre_rst_valid", 72'(tif.out_valid), 72'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 72'(tif.out_valid), 72'd0);
    check("async_rst_drop", 72'(tif.drop_cnt), 72'd0);
    @(posedge clk); #1 rst = 1'b0;
    tif.out_ready = 1'b1;
    cyc(1, 900, 32'h104, 0);
    cyc(1, 901, 32'h108, 0);
    cyc(1, 902, 32'h100, 0);
    cyc(1, 903, 32'h104, 0);
    cyc(1, 904, 32'h400, 0);
    idle(3);
    check("post_rst_count", 72'(got.size()), 72'd1);
    check_got("post_rst_msg", 0, mk(902, 32'h100, 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/itm_trace_compression_param.md
Name: itm_trace_compression_param

Overview:
Parametrised successor of the ITM trace compressor. Converts a per-instruction {timestamp, writeback PC} stream into one message per dynamic basic block: {start timestamp, start address, instruction count}. Adds counter-overflow splitting, an explicit flush, an output FIFO with valid/ready backpressure, and drop accounting. Sits between the core trace tap and the ITM packetiser.

Parameters:
TS_WIDTH, 32, timestamp width
PC_WIDTH, 32, PC/address width
CNT_WIDTH, 8, instruction-count field width (max count 2^CNT_WIDTH-1)
PC_STEP, 4, PC increment treated as sequential
BOOT_ADR, 32'h100, PC that starts tracing after reset
FIFO_DEPTH, 4, output message FIFO depth (power of two, >=2)
DROP_WIDTH, 16, width of dropped-message counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
trace_in  in  TS_WIDTH+PC_WIDTH  {ts, pc}; pc in [PC_WIDTH-1:0]
trace_in_valid  in  1  trace_in qualifier
flush  in  1  emit the open block now
out_data  out  TS_WIDTH+PC_WIDTH+CNT_WIDTH  {stream_ts, stream_sa, cnt}
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data
drop_cnt  out  DROP_WIDTH  saturating count of lost messages
drop_pulse  out  1  one-cycle pulse per lost message

Behaviour:
- One clock; reset is asynchronous and active-high. On reset: state=WAIT_BOOT, prev_pc=0, cnt=0, stream_sa=0, stream_ts=0, FIFO empty, out_valid=0, out_data=0, drop_cnt=0, drop_pulse=0. Reset asserted mid-operation discards the open block and all FIFO contents.
- Accepted input: trace_in_valid && pc!=0 && (state==RUN || pc==BOOT_ADR). All other inputs are ignored: no state change, prev_pc kept.
- WAIT_BOOT + accepted: stream_sa=pc, stream_ts=ts, cnt=1, prev_pc=pc, go RUN. No message.
- RUN + accepted, sequential (pc==prev_pc+PC_STEP mod 2^PC_WIDTH, or pc==prev_pc) with 0<cnt<max: cnt+=1.
- RUN + accepted, sequential with cnt==max (all ones): emit {stream_ts, stream_sa, max}, then open a new stream at pc with cnt=1.
- RUN + accepted, non-sequential, or cnt==0 (after a flush): emit the open block if cnt!=0, then open a new stream at pc with cnt=1.
- prev_pc<=pc on every accepted input.
- flush in RUN with cnt!=0: emit the open block and set cnt=0. With a simultaneous accepted input, the emit covers the block before that input, and the input opens a new stream with cnt=1. At most one emit per cycle. flush in WAIT_BOOT or with cnt==0 is a no-op.
- Emit = FIFO push. Data appears on out_data/out_valid the cycle after the triggering clock edge when the FIFO was empty (one-cycle latency).
- Pop on out_valid && out_ready. out_data is the FIFO head and holds stable while out_valid && !out_ready.
- Full FIFO: a push with a simultaneous pop succeeds. A push to a full FIFO without a pop is dropped: the message is lost, drop_pulse=1 for one cycle, and drop_cnt increments, saturating at all ones. Compression state still advances as if the emit succeeded.
- Empty FIFO: no pop occurs regardless of out_ready.
- All arithmetic is unsigned and modulo its field width, except drop_cnt, which saturates.

Test Plan:
- Boot sync: feed pc 0x50, 0x0, then 0x100 (ts=10), 0x104, 0x108, 0x200 (ts=13) -> exactly one message {10, 0x100, 3}; 0x50 and 0x0 produce nothing.
- Repeat/stall PCs: 0x100, 0x100, 0x104, 0x300 -> message cnt=3; idle cycles with trace_in_valid=0 between inputs leave the count unchanged.
- Overflow split (CNT_WIDTH=8): 256 sequential PCs from 0x100 -> message {ts0, 0x100, 255} on the 256th input; the new stream starts at 0x4FC with cnt=1; a branch then emits {ts255, 0x4FC, 1}.
- Flush: 0x100, 0x104, flush -> {ts, 0x100, 2}. A following 0x108 starts a new stream at 0x108, not a continuation. flush together with a 0x10C input -> one message for the prior block; the new stream starts at 0x10C.
- Backpressure (FIFO_DEPTH=4): hold out_ready=0 and cause 6 block emits -> 4 messages stored in order, drop_cnt=2, two drop_pulses. Release out_ready -> 4 messages drain, one per cycle, in order. Push and pop in the same cycle when full -> no drop.
- Asynchronous reset mid-block with 2 messages queued -> out_valid=0 immediately, drop_cnt=0; a subsequent non-boot PC is ignored until BOOT_ADR is seen again.
